// File: rtl/systolic_fir_array.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_fir_array
//  Description : TAPS-deep transposed-form multiply-accumulate array computing
//                y[n] = sum_k c_k * x[n-k] over a valid/ready sample stream.
//                Coefficients are double-buffered: a shadow bank is loaded
//                beat by beat while the active bank keeps filtering, then
//                swapped in during a one-cycle COMMIT state.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_fir_array #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int TAPS   = 4,
   parameter int SIGNED = 0,
   parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              coef_start,
   input  logic              coef_valid,
   input  logic [COEF_W-1:0] coef_in,
   output logic              coef_ready,
   output logic              cfg_valid,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_x,
   output logic              out_valid,
   output logic [ACC_W-1:0]  out_y
);

   localparam int                 c_CNT_W     = $clog2(TAPS);
   localparam int                 c_PROD_W    = DATA_W + COEF_W;
   localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(TAPS - 1);
   localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_COMMIT = 2'd2,
      S_RUN    = 2'd3
   } state_t;

   // Control state and coefficient banks
   state_t              r_state;
   logic [c_CNT_W-1:0]  r_beat_cnt;
   logic [COEF_W-1:0]   r_shadow [TAPS];
   logic [COEF_W-1:0]   r_active [TAPS];
   logic                r_cfg_valid;

   // Datapath: input register, partial-sum chain, output register
   logic [DATA_W-1:0]   r_x;
   logic                r_v;
   logic [ACC_W-1:0]    r_acc [TAPS];
   logic                r_out_valid;
   logic [ACC_W-1:0]    r_out_y;

   logic [ACC_W-1:0]    w_prod [TAPS];
   logic [ACC_W-1:0]    w_next [TAPS];
   logic                w_last_beat;
   logic                w_accept;

   // The cycle that takes the final beat is followed by COMMIT; blocking
   // samples in both cycles keeps the partial-sum chain empty at the swap,
   // so no sample ever mixes coefficients from two banks.
   assign w_last_beat = (r_state == S_LOAD) && (r_beat_cnt == c_LAST_BEAT);
   assign in_ready    = r_cfg_valid && !w_last_beat && (r_state != S_COMMIT);
   assign coef_ready  = (r_state == S_LOAD);
   assign cfg_valid   = r_cfg_valid;
   assign w_accept    = in_valid && in_ready;
   assign out_valid   = r_out_valid;
   assign out_y       = r_out_y;

   // Coefficient load FSM: IDLE/RUN -> LOAD -> COMMIT -> RUN, banks and beat counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_beat_cnt  <= '0;
         r_cfg_valid <= 1'b0;
         for (int k = 0; k < TAPS; k++) begin
            r_shadow[k] <= '0;
            r_active[k] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (coef_start) begin
                  r_state    <= S_LOAD;
                  r_beat_cnt <= '0;
               end
            end
            S_LOAD: begin
               if (coef_valid) begin
                  r_shadow[r_beat_cnt] <= coef_in;
                  if (r_beat_cnt == c_LAST_BEAT) begin
                     r_state    <= S_COMMIT;
                     r_beat_cnt <= '0;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + c_ONE;
                  end
               end
            end
            S_COMMIT: begin
               for (int k = 0; k < TAPS; k++) begin
                  r_active[k] <= r_shadow[k];
               end
               r_cfg_valid <= 1'b1;
               r_state     <= S_RUN;
            end
            S_RUN: begin
               if (coef_start) begin
                  r_state    <= S_LOAD;
                  r_beat_cnt <= '0;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Stage 1: capture an accepted sample; x holds across bubbles
   always_ff @(posedge clk) begin
      if (reset) begin
         r_x <= '0;
         r_v <= 1'b0;
      end else begin
         r_v <= w_accept;
         if (w_accept) begin
            r_x <= in_x;
         end
      end
   end

   // Per-tap product, extended to full accumulator width, and the next
   // partial sum feeding the stage below it in the transposed chain.
   for (genvar k = 0; k < TAPS; k++) begin : g_tap
      logic [c_PROD_W-1:0] w_p;

      if (SIGNED != 0) begin : g_signed
         assign w_p       = $signed(r_active[k]) * $signed(r_x);
         assign w_prod[k] = {{(ACC_W - c_PROD_W){w_p[c_PROD_W-1]}}, w_p};
      end else begin : g_unsigned
         assign w_p       = r_active[k] * r_x;
         assign w_prod[k] = {{(ACC_W - c_PROD_W){1'b0}}, w_p};
      end

      if (k == TAPS - 1) begin : g_tail
         assign w_next[k] = w_prod[k];
      end else begin : g_chain
         assign w_next[k] = r_acc[k+1] + w_prod[k];
      end
   end

   // Stage 2: advance the partial-sum chain only on real samples; COMMIT
   // clears history so the new bank starts from x=0. out_y mirrors r_acc[0]
   // as last written by a sample, so it holds through COMMIT and bubbles.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < TAPS; k++) begin
            r_acc[k] <= '0;
         end
         r_out_valid <= 1'b0;
         r_out_y     <= '0;
      end else begin
         r_out_valid <= r_v;
         if (r_state == S_COMMIT) begin
            for (int k = 0; k < TAPS; k++) begin
               r_acc[k] <= '0;
            end
         end else if (r_v) begin
            for (int k = 0; k < TAPS; k++) begin
               r_acc[k] <= w_next[k];
            end
            r_out_y <= w_next[0];
         end
      end
   end

endmodule
`default_nettype wire
